// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder: default group size,
// group-count helper, P/G pair type and a sum-of-products lookahead carry function.
package cla_pkg;

    localparam int GROUP_DEFAULT = 4;
    localparam int LA_MAX        = 64;

    typedef struct packed {
        logic p;
        logic g;
    } pg_t;

    function automatic int group_count(input int width, input int group);
        return width / group;
    endfunction

    // Carry into position n of a chain: OR of every generate (or ci) propagated
    // through all intervening P bits. Flat two-level form, no ripple.
    function automatic logic carry_la(input logic [LA_MAX-1:0] p,
                                      input logic [LA_MAX-1:0] g,
                                      input logic              ci,
                                      input int                n);
        logic c;
        logic t;
        t = ci;
        for (int k = 0; k < n; k++) t = t & p[k];
        c = t;
        for (int j = 0; j < n; j++) begin
            t = g[j];
            for (int k = j + 1; k < n; k++) t = t & p[k];
            c = c | t;
        end
        return c;
    endfunction

endpackage

// File: rtl/cla_group.sv
// Combinational GROUP-bit lookahead unit: per-bit carries from a group carry-in,
// plus group propagate/generate.
module cla_group
    import cla_pkg::*;
#(
    parameter int GROUP = GROUP_DEFAULT
) (
    input  logic [GROUP-1:0] p,
    input  logic [GROUP-1:0] g,
    input  logic             ci,
    output logic [GROUP-1:0] c,
    output logic             pg,
    output logic             gg
);

    always_comb begin
        c = '0;
        for (int i = 0; i < GROUP; i++) begin
            c[i] = carry_la(LA_MAX'(p), LA_MAX'(g), ci, i);
        end
        pg = &p;
        gg = carry_la(LA_MAX'(p), LA_MAX'(g), 1'b0, GROUP);
    end

endmodule

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// Optional ovf/zero outputs are enabled by defining CLA_PIPE_ADDER_FLAGS_EN.
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int GROUP = GROUP_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CLA_PIPE_ADDER_FLAGS_EN
    ,
    output logic             ovf,
    output logic             zero
`endif
);

    localparam int NG = group_count(WIDTH, GROUP);

    // Handshake: a stage moves when its successor is empty or is handing off this cycle.
    logic s1_valid, s2_valid;
    assign in_ready  = !s1_valid || !s2_valid || out_ready;
    assign out_valid = s2_valid;

    logic [WIDTH-1:0] b_eff, p_d, g_d;
    logic [NG-1:0]    pg_d, gg_d;

    always_comb begin
        b_eff = sub ? ~b : b;
        p_d   = a ^ b_eff;
        g_d   = a & b_eff;
        pg_d  = '0;
        gg_d  = '0;
        for (int k = 0; k < NG; k++) begin
            pg_d[k] = &p_d[k*GROUP +: GROUP];
            gg_d[k] = carry_la(LA_MAX'(p_d[k*GROUP +: GROUP]),
                               LA_MAX'(g_d[k*GROUP +: GROUP]), 1'b0, GROUP);
        end
    end

    pg_t [WIDTH-1:0] s1_bit;
    logic            s1_cin;
    logic [NG-1:0]   s1_pg, s1_gg;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                for (int i = 0; i < WIDTH; i++) s1_bit[i] <= '{p: p_d[i], g: g_d[i]};
                s1_cin <= cin;
                s1_pg  <= pg_d;
                s1_gg  <= gg_d;
            end
        end
    end

    logic [WIDTH-1:0] p_q, g_q, bit_c, sum_d;
    logic [NG-1:0]    grp_c, inst_pg, inst_gg;
    logic             cout_d;

    // Group carries straight from the registered group P/G; no group waits on another.
    always_comb begin
        p_q   = '0;
        g_q   = '0;
        grp_c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            p_q[i] = s1_bit[i].p;
            g_q[i] = s1_bit[i].g;
        end
        for (int k = 0; k < NG; k++) begin
            grp_c[k] = carry_la(LA_MAX'(s1_pg), LA_MAX'(s1_gg), s1_cin, k);
        end
    end

    for (genvar k = 0; k < NG; k++) begin : g_grp
        cla_group #(.GROUP(GROUP)) u_grp (
            .p  (p_q[k*GROUP +: GROUP]),
            .g  (g_q[k*GROUP +: GROUP]),
            .ci (grp_c[k]),
            .c  (bit_c[k*GROUP +: GROUP]),
            .pg (inst_pg[k]),
            .gg (inst_gg[k])
        );
    end

    assign sum_d  = p_q ^ bit_c;
    assign cout_d = carry_la(LA_MAX'(inst_pg), LA_MAX'(inst_gg), s1_cin, NG);

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
`ifdef CLA_PIPE_ADDER_FLAGS_EN
            ovf      <= 1'b0;
            zero     <= 1'b0;
`endif
        end else if (!s2_valid || out_ready) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                sum  <= sum_d;
                cout <= cout_d;
`ifdef CLA_PIPE_ADDER_FLAGS_EN
                ovf  <= cout_d ^ bit_c[WIDTH-1];
                zero <= (sum_d == '0);
`endif
            end
        end
    end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder: directed corner vectors, stall and reset
// scenarios, and randomized traffic checked against an integer-arithmetic model.
module tb_cla_pipe_adder;

    localparam int W  = 16;
    localparam int EW = W + 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0, in_ready;
    logic [W-1:0] a = '0, b = '0, sum;
    logic         cin = 1'b0, sub = 1'b0;
    logic         out_valid, out_ready = 1'b0, cout;
`ifdef CLA_PIPE_ADDER_FLAGS_EN
    logic         ovf, zero;
`endif

    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];

    always #5 clk = ~clk;

    cla_pipe_adder #(.WIDTH(W), .GROUP(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef CLA_PIPE_ADDER_FLAGS_EN
        ,
        .ovf       (ovf),
        .zero      (zero)
`endif
    );

    // Result packing {ovf, zero, cout, sum}; flag bits only compared when present.
`ifdef CLA_PIPE_ADDER_FLAGS_EN
    localparam logic [EW-1:0] MASK = '1;
    function automatic logic [EW-1:0] obs();
        return {ovf, zero, cout, sum};
    endfunction
`else
    localparam logic [EW-1:0] MASK = {2'b00, {(W+1){1'b1}}};
    function automatic logic [EW-1:0] obs();
        return {2'b00, cout, sum};
    endfunction
`endif

    function automatic logic [EW-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic ci, input logic s);
        longint ux, uy, sx, sy, r, sr;
        logic co, ov;
        logic [W-1:0] res;
        ux = longint'(x);
        uy = longint'(y);
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (s) begin
            r  = ux - uy - (ci ? 0 : 1);
            sr = sx - sy - (ci ? 0 : 1);
            co = (r >= 0);
        end else begin
            r  = ux + uy + longint'(ci);
            sr = sx + sy + longint'(ci);
            co = (r >= (longint'(1) << W));
        end
        res = r[W-1:0];
        ov  = (sr > (longint'(1) << (W-1)) - 1) || (sr < -(longint'(1) << (W-1)));
        return {ov, (res == '0), co, res};
    endfunction

    function automatic logic [W-1:0] rand_op();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(W-1){1'b0}}};
            3:       return {1'b0, {(W-1){1'b1}}};
            default: return W'($urandom);
        endcase
    endfunction

    task automatic drive(input logic v, input logic [W-1:0] aa, input logic [W-1:0] bb,
                         input logic c, input logic s, input logic ordy);
        in_valid  = v;
        a         = aa;
        b         = bb;
        cin       = c;
        sub       = s;
        out_ready = ordy;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        checks++; if (sum !== '0) begin errors++; $display("FAIL reset_sum got %h exp 0", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout got %b exp 0", cout); end
`ifdef CLA_PIPE_ADDER_FLAGS_EN
        checks++; if ({ovf, zero} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b exp 00", {ovf, zero}); end
`endif
    endtask

    task automatic test_vectors();
        logic [W-1:0]  va[5];
        logic [W-1:0]  vb[5];
        logic          vc[5];
        logic          vs[5];
        logic [EW-1:0] ve[5];
        // expected {ovf, zero, cout, sum} worked out by hand
        va[0] = 16'hFFFF; vb[0] = 16'h0001; vc[0] = 1'b0; vs[0] = 1'b0; ve[0] = {1'b0, 1'b1, 1'b1, 16'h0000};
        va[1] = 16'h7FFF; vb[1] = 16'h0001; vc[1] = 1'b0; vs[1] = 1'b0; ve[1] = {1'b1, 1'b0, 1'b0, 16'h8000};
        va[2] = 16'h0005; vb[2] = 16'h0007; vc[2] = 1'b1; vs[2] = 1'b1; ve[2] = {1'b0, 1'b0, 1'b0, 16'hFFFE};
        va[3] = 16'h8000; vb[3] = 16'h0001; vc[3] = 1'b1; vs[3] = 1'b1; ve[3] = {1'b1, 1'b0, 1'b1, 16'h7FFF};
        va[4] = 16'h1234; vb[4] = 16'h4321; vc[4] = 1'b1; vs[4] = 1'b0; ve[4] = {1'b0, 1'b0, 1'b0, 16'h5556};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(1'b1, va[i], vb[i], vc[i], vs[i], 1'b1);
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL vec%0d_in_ready got %b exp 1", i, in_ready); end
            @(negedge clk);
            drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
            #1;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL vec%0d_early_valid got %b exp 0", i, out_valid); end
            @(negedge clk);
            #1;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL vec%0d_latency got out_valid %b exp 1", i, out_valid); end
            checks++;
            if ((obs() & MASK) !== (ve[i] & MASK)) begin
                errors++; $display("FAIL vec%0d_result got %h exp %h", i, obs() & MASK, ve[i] & MASK);
            end
        end
    endtask

    task automatic test_back_to_back_stall();
        int sent = 0, recv = 0;
        logic held = 1'b0, saw_block = 1'b0;
        logic [EW-1:0] held_v, e;
        logic [W-1:0] xa, xb;
        logic xc, xs;
        xa = rand_op(); xb = rand_op(); xc = 1'($urandom); xs = 1'($urandom);
        for (int cyc = 0; cyc < 60 && recv < 8; cyc++) begin
            @(negedge clk);
            drive(sent < 8, xa, xb, xc, xs, !(cyc >= 3 && cyc <= 6));
            #1;
            if (held) begin
                checks++;
                if ((obs() & MASK) !== (held_v & MASK)) begin
                    errors++; $display("FAIL stall_hold got %h exp %h", obs() & MASK, held_v & MASK);
                end
            end
            if (sent < 8 && !in_ready) saw_block = 1'b1;
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL stall_extra got result %h exp none", obs() & MASK);
                end else begin
                    e = exp_q.pop_front();
                    if ((obs() & MASK) !== (e & MASK)) begin
                        errors++; $display("FAIL stall_order got %h exp %h", obs() & MASK, e & MASK);
                    end
                end
                recv++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(xa, xb, xc, xs));
                sent++;
                xa = rand_op(); xb = rand_op(); xc = 1'($urandom); xs = 1'($urandom);
            end
            held   = out_valid && !out_ready;
            held_v = obs();
        end
        checks++; if (recv != 8) begin errors++; $display("FAIL stall_count got %0d exp 8", recv); end
        checks++; if (saw_block !== 1'b1) begin errors++; $display("FAIL stall_backpressure got in_ready never low exp low"); end
    endtask

    task automatic test_reset_midflight();
        logic [EW-1:0] e;
        int seen;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1'b1, rand_op(), rand_op(), 1'($urandom), 1'($urandom), 1'b0);
        end
        @(negedge clk);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst_full got in_ready %b exp 0", in_ready); end
        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b exp 0", out_valid); end
        checks++; if ({cout, sum} !== '0) begin errors++; $display("FAIL midrst_sum got %h exp 0", {cout, sum}); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b exp 1", in_ready); end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
            #1;
            if (out_valid) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL midrst_stale got %0d results exp 0", seen); end
        @(negedge clk);
        drive(1'b1, 16'h00FF, 16'h0F01, 1'b0, 1'b0, 1'b1);
        e = model(16'h00FF, 16'h0F01, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || (obs() & MASK) !== (e & MASK)) begin
            errors++; $display("FAIL midrst_recover got v=%b %h exp v=1 %h", out_valid, obs() & MASK, e & MASK);
        end
    endtask

    task automatic test_random();
        int sent = 0, recv = 0;
        logic held = 1'b0;
        logic [EW-1:0] held_v, e;
        logic [W-1:0] xa, xb;
        logic xc, xs, xv;
        xa = rand_op(); xb = rand_op(); xc = 1'($urandom); xs = 1'($urandom);
        xv = ($urandom_range(0, 3) != 0);
        for (int cyc = 0; cyc < 20000 && !(sent >= 3000 && exp_q.size() == 0); cyc++) begin
            @(negedge clk);
            drive(xv && sent < 3000, xa, xb, xc, xs, (sent >= 3000) || ($urandom_range(0, 3) != 0));
            #1;
            if (held) begin
                checks++;
                if ((obs() & MASK) !== (held_v & MASK)) begin
                    errors++; $display("FAIL rand_hold got %h exp %h", obs() & MASK, held_v & MASK);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rand_extra got result %h exp none", obs() & MASK);
                end else begin
                    e = exp_q.pop_front();
                    if ((obs() & MASK) !== (e & MASK)) begin
                        errors++; $display("FAIL rand_result got %h exp %h", obs() & MASK, e & MASK);
                    end
                end
                recv++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(xa, xb, xc, xs));
                sent++;
                xa = rand_op(); xb = rand_op(); xc = 1'($urandom); xs = 1'($urandom);
                xv = ($urandom_range(0, 3) != 0);
            end else if (!in_valid) begin
                xv = ($urandom_range(0, 3) != 0);
            end
            held   = out_valid && !out_ready;
            held_v = obs();
        end
        checks++; if (recv != 3000) begin errors++; $display("FAIL rand_count got %0d exp 3000", recv); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_leftover got %0d exp 0", exp_q.size()); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_vectors();
        test_back_to_back_stall();
        test_reset_midflight();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cla_pipe_adder.md
CLA_PIPE_ADDER -- requirements
Module: cla_pipe_adder

Interface
REQ-001 Parameter WIDTH, default 16: operand width in bits; SHALL be a multiple of GROUP and at least 4.
REQ-002 Parameter GROUP, default 4: bits per lookahead group.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand set presented.
REQ-006 in_ready  output  1  block accepts the operand set this cycle.
REQ-007 a, b  input  WIDTH each  operands.
REQ-008 cin  input  1  carry-in.
REQ-009 sub  input  1  1 = compute a - b - !cin (b inverted, cin used as borrow-not); 0 = a + b + cin.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 sum  output  WIDTH  result bits.
REQ-013 cout  output  1  carry-out of MSB (for sub: 1 = no borrow).

Function
REQ-014 Transfer in: in_valid && in_ready on a rising edge; transfer out: out_valid && out_ready.
REQ-015 Two pipeline stages: S1 registers per-bit P = a^b', G = a&b' (b' = sub ? ~b : b), cin and per-group PG/GG; S2 registers sum, cout.
REQ-016 Latency: exactly 2 cycles from input transfer to out_valid with no stall; throughput 1 result/cycle.
REQ-017 Group carries: C[k+1] = GG[k] | PG[k]&C[k], C[0] = cin; all carries computed in lookahead form within S2, no ripple across groups.
REQ-018 sum[i] = P[i] ^ c[i]; cout = carry out of bit WIDTH-1; arithmetic modulo 2^WIDTH.
REQ-019 Stall: S2 holds when out_valid && !out_ready; S1 advances only if S2 is empty or draining.
REQ-020 in_ready = !s1_valid || !s2_valid || out_ready (combinational; no bubble on continuous flow).
REQ-021 sum, cout SHALL remain stable while out_valid && !out_ready.
REQ-022 Simultaneous input and output transfer with both stages full: both advance, no data lost or duplicated.
REQ-023 in_valid without in_ready: operands ignored, no state change.

Reset
REQ-024 While rst = 1 at a rising edge: s1_valid, s2_valid, out_valid = 0; sum = 0; cout = 0; in_ready = 1 the cycle after.
REQ-025 Reset mid-operation discards all in-flight results; no out_valid in the cycle following reset.

Configuration
REQ-026 Macro CLA_PIPE_ADDER_FLAGS_EN defined: extra outputs ovf (signed overflow, = c[WIDTH] ^ c[WIDTH-1]) and zero (sum == 0), registered in S2 with sum, reset to 0.
REQ-027 Macro undefined: ovf and zero ports absent; all other behaviour identical.

Structure
REQ-028 Shared package cla_pkg: GROUP default constant, function computing group count WIDTH/GROUP, typedef for a P/G pair.
REQ-029 One sub-module cla_group: combinational GROUP-bit lookahead unit (inputs P, G, carry-in; outputs internal carries, group PG, GG), instantiated WIDTH/GROUP times in S2.

Verification
REQ-030 WIDTH=16, a=16'hFFFF, b=16'h0001, cin=0, sub=0 -> 2 cycles later sum=16'h0000, cout=1 (zero=1, ovf=0 if flags enabled).
REQ-031 a=16'h7FFF, b=16'h0001, sub=0, cin=0 -> sum=16'h8000, cout=0, ovf=1.
REQ-032 a=16'h0005, b=16'h0007, sub=1, cin=1 -> sum=16'hFFFE, cout=0 (borrow).
REQ-033 Back-to-back 8 transfers, out_ready held 0 for cycles 3-6 -> in_ready drops once both stages full; all 8 results emerge in order, unchanged while stalled.
REQ-034 rst asserted 1 cycle with both stages full -> out_valid=0 next cycle, sum=0, no stale result later.
REQ-035 Random 10k operand sets, WIDTH in {4,16,32}, random out_ready -> every result equals reference a±b model, in order, none dropped.
